// File: rtl/qspi_rom_pkg.sv
// ==========================================================================
// qspi_rom_pkg : state encoding, command default and phase lengths
// Revision     : 1.0
// ==========================================================================
`default_nettype none

package qspi_rom_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [7:0] c_CMD_DEFAULT  = 8'hEB;
  localparam int         c_CMD_NIBBLES  = 2;
  localparam int         c_ADDR_NIBBLES = 6;
  localparam int         c_DATA_NIBBLES = 2;

  // Address nibble idx of a 24-bit address, most significant first.
  function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [3:0] idx);
    logic [3:0] nib;
    case (idx)
      4'd0:    nib = addr[23:20];
      4'd1:    nib = addr[19:16];
      4'd2:    nib = addr[15:12];
      4'd3:    nib = addr[11:8];
      4'd4:    nib = addr[7:4];
      4'd5:    nib = addr[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_arb_grant.sv
// ==========================================================================
// qspi_arb_grant : two-requester grant, fixed priority to requester 0, or
//                  alternating on contention when QSPI_ARB_ROUND_ROBIN_EN
// Revision       : 1.0
// ==========================================================================
`default_nettype none

module qspi_arb_grant (
  input  logic valid0,
  input  logic valid1,
  input  logic idle,
`ifdef QSPI_ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (idle) begin
`ifdef QSPI_ARB_ROUND_ROBIN_EN
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
`else
      grant0 = valid0;
      grant1 = valid1 & ~valid0;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/qspi_rom_arbiter.sv
// ==========================================================================
// qspi_rom_arbiter : two-port byte reader for a quad-SPI ROM (cmd, 24-bit
//                    addr, dummy, one data byte); build option
//                    QSPI_ARB_ROUND_ROBIN_EN selects alternating arbitration
// Revision         : 1.0
// ==========================================================================
`default_nettype none

module qspi_rom_arbiter
  import qspi_rom_pkg::*;
#(
  parameter int         ADDR_W = 12,
  parameter int         DUMMY  = 4,
  parameter logic [7:0] CMD    = c_CMD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic              qspi_select,
  output logic              qspi_sclk,
  output logic [3:0]        qspi_dout,
  input  logic [3:0]        qspi_din
);

  state_t            r_state, w_state_next;
  logic              r_phase;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_id;
  logic [3:0]        r_data_hi;
  logic [7:0]        r_rsp_data;

  logic              w_idle, w_grant0, w_grant1;
  logic              w_accept0, w_accept1, w_accept;
  logic [3:0]        w_last_idx;
  logic              w_nibble_end;
  logic [23:0]       w_addr24;

  // Reset also masks the grants so ready is low while reset is held.
  assign w_idle = (r_state == ST_IDLE) && !reset;

`ifdef QSPI_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_accept1;
  end
`endif

  qspi_arb_grant u_grant (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .idle       (w_idle),
`ifdef QSPI_ARB_ROUND_ROBIN_EN
    .last_grant (r_last_grant),
`endif
    .grant0     (w_grant0),
    .grant1     (w_grant1)
  );

  assign w_accept0 = req0_valid & w_grant0;
  assign w_accept1 = req1_valid & w_grant1;
  assign w_accept  = w_accept0 | w_accept1;
  assign w_addr24  = 24'(r_addr);

  always_comb begin
    w_last_idx = 4'd0;
    case (r_state)
      ST_CMD:   w_last_idx = 4'(c_CMD_NIBBLES - 1);
      ST_ADDR:  w_last_idx = 4'(c_ADDR_NIBBLES - 1);
      ST_DUMMY: w_last_idx = 4'(DUMMY - 1);
      ST_DATA:  w_last_idx = 4'(c_DATA_NIBBLES - 1);
      default:  w_last_idx = 4'd0;
    endcase
  end

  // A phase ends on the sclk-high half of its final nibble.
  assign w_nibble_end = r_phase && (r_cnt == w_last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)     w_state_next = ST_CMD;
      ST_CMD:   if (w_nibble_end) w_state_next = ST_ADDR;
      ST_ADDR:  if (w_nibble_end) w_state_next = (DUMMY == 0) ? ST_DATA : ST_DUMMY;
      ST_DUMMY: if (w_nibble_end) w_state_next = ST_DATA;
      ST_DATA:  if (w_nibble_end) w_state_next = ST_DONE;
      ST_DONE:                    w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= 1'b0;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_id       <= 1'b0;
      r_data_hi  <= 4'h0;
      r_rsp_data <= 8'h00;
    end else begin
      if (w_accept) begin
        r_addr <= w_accept1 ? req1_addr : req0_addr;
        r_id   <= w_accept1;
      end
      if (r_state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA}) begin
        r_phase <= ~r_phase;
        if (r_phase) r_cnt <= w_nibble_end ? 4'd0 : r_cnt + 4'd1;
        // Read data is sampled at the end of each sclk-high cycle.
        if (r_phase && (r_state == ST_DATA)) begin
          if (r_cnt == 4'd0) r_data_hi  <= qspi_din;
          else               r_rsp_data <= {r_data_hi, qspi_din};
        end
      end else begin
        r_phase <= 1'b0;
        r_cnt   <= 4'd0;
      end
    end
  end

  assign rsp_data = r_rsp_data;

  always_comb begin
    qspi_select = 1'b1;
    qspi_sclk   = 1'b0;
    qspi_dout   = 4'h0;
    busy        = (r_state != ST_IDLE);
    req0_ready  = w_grant0;
    req1_ready  = w_grant1;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      ST_CMD: begin
        qspi_select = 1'b0;
        qspi_sclk   = r_phase;
        qspi_dout   = r_cnt[0] ? CMD[3:0] : CMD[7:4];
      end
      ST_ADDR: begin
        qspi_select = 1'b0;
        qspi_sclk   = r_phase;
        qspi_dout   = addr_nibble(w_addr24, r_cnt);
      end
      ST_DUMMY, ST_DATA: begin
        qspi_select = 1'b0;
        qspi_sclk   = r_phase;
      end
      ST_DONE: begin
        rsp0_valid = ~r_id;
        rsp1_valid = r_id;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
